regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register file's single write port among several writeback sources (ALU, load unit, move/immediate path) with round-robin fairness and a valid/ready handshake per source. It also provides a sequenced software clear that zeroes all 32 registers through the normal write port, one register per cycle. The block sits between the execute/writeback stages and the register file write port. Every write it issues is registered.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 16, register data width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- clear_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data, packed the same way as req_addr
- req_ready  out  NREQ  per-requester grant (combinational); at most one bit set
- clr_req  in  1  start a full-file clear sequence (level, sampled in ARB only)
- clr_busy  out  1  high while in CLEAR state
- clr_done  out  1  one-cycle pulse, concurrent with the last clear write
- rf_write_en  out  1  registered write enable to the register file
- rf_write_addr  out  ADDR_W  registered write address
- rf_write_data  out  DATA_W  registered write data

## Operation
- States: ARB and CLEAR. Reset state is ARB.
- ARB without clr_req:
  - Grant the first requester with valid=1, searching from rr_ptr upward, modulo NREQ.
  - req_ready is asserted only for that requester.
  - A transfer occurs when valid and ready are both high.
  - On a transfer, the output register loads the granted requester's address and data with en=1, and rr_ptr becomes (grantee+1) mod NREQ.
  - With no valid requester: en loads 0, and addr/data hold their previous values.
- ARB with clr_req=1:
  - All req_ready are 0 that cycle, so clear beats any simultaneous request.
  - Next state is CLEAR, clr_cnt=0, en loads 0.
- CLEAR:
  - Each edge loads addr=clr_cnt, data=0, en=1, then increments clr_cnt.
  - req_ready is all 0. clr_req is ignored.
  - At the edge where clr_cnt=31: clr_done loads 1, state returns to ARB, clr_cnt wraps to 0.
- rr_ptr is unchanged by a clear.
- Requester rules: a requester must hold valid, addr and data stable until it sees ready. The arbiter does not check this rule.
- Reset (clear_n=0), at any time including mid-CLEAR:
  - state=ARB, rr_ptr=0, clr_cnt=0
  - rf_write_en=0, rf_write_addr=0, rf_write_data=0, clr_done=0
  - A clear in progress is abandoned; the register file is left partially cleared.
- Combinational reset values: req_ready=0 and clr_busy=0 follow from state=ARB with no valid requests.

## Timing
- Write latency: a transfer at edge k makes rf_write_en=1 during cycle k+1, and the register file captures it at edge k+1.
- Throughput: one write per cycle. Back-to-back grants to the same or different requesters are allowed.
- Clear sequence: clr_req sampled at edge k. Addresses 0..31 appear on consecutive cycles k+2..k+33, with clr_done=1 in cycle k+33. req_ready can be asserted again in cycle k+33.
- clr_busy is a decode of state; it is high for cycles k+1..k+32.

## Configuration
- RF_WR_ZERO_PROTECT_EN defined:
  - A requester write to address 0 still completes its handshake and advances rr_ptr.
  - rf_write_en loads 0 for that write, so R0 stays hardwired to zero.
  - Clear writes to address 0 are still issued.
- RF_WR_ZERO_PROTECT_EN undefined: address 0 is written like any other register.

## Structure
- Shared package regfile_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=16, RF_DEPTH=32
  - the state enum {ARB, CLEAR}
- Sub-module rr_arbiter: parameter NREQ; inputs valid vector, rr_ptr and enable; outputs a one-hot grant and the grant index. It is purely combinational. The pointer register stays in the top module.

## Test plan
- Reset: clear_n low mid-operation -> all registered outputs 0, req_ready 0, state ARB. After release with only req0 valid (addr 3, data 0x1234) -> ready0=1; next cycle en=1, addr=3, data=0x1234.
- Fairness: all three requesters continuously valid for 6 cycles -> grant order 0,1,2,0,1,2, and rf_write_addr sequence matches each requester's address with one cycle of lag.
- Pointer skip: rr_ptr=1, only req2 and req0 valid -> req2 granted, then req0; rr_ptr ends at 1.
- Clear collision: clr_req and req1 valid (addr 7, data 0xBEEF) in the same cycle -> no ready. 32 writes follow with addr 0..31 and data 0, and clr_done coincides with addr 31. req1 is granted in that same cycle and its write appears next.
- Reset mid-clear: clear_n low while writing addr 12 -> en=0 and state ARB. After release, clr_req restarts the sequence from addr 0.
- Zero protect, with RF_WR_ZERO_PROTECT_EN defined: req0 writes addr 0, data 0xFFFF -> ready0=1, rr_ptr advances, en stays 0. Without the macro -> en=1, addr=0, data=0xFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter: geometry and controller states.
package regfile_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 16;
   localparam int RF_DEPTH  = 32;

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } rf_wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first valid requester at or above rr_ptr_i,
// wrapping modulo NREQ. The pointer itself lives in the instantiating module.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  valid_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   input  logic             enable_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   // Scanning from the farthest candidate back toward rr_ptr_i lets the nearest one win last.
   always_comb begin
      logic [IDX_W-1:0] cand;
      grant_o     = '0;
      grant_idx_o = '0;
      cand        = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(rr_ptr_i) + k) % NREQ);
         if (enable_i && valid_i[cand]) begin
            grant_o       = '0;
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a sequenced full-file clear.
// Optional feature: define RF_WR_ZERO_PROTECT_EN to suppress requester writes to R0.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic                     clk,
   input  logic                     clear_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     rf_write_en,
   output logic [ADDR_W-1:0]        rf_write_addr,
   output logic [DATA_W-1:0]        rf_write_data
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(RF_DEPTH);

   rf_wr_state_e      state_q, state_d;
   logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
   logic [CNT_W-1:0]  clrCnt_q, clrCnt_d;
   logic              wrEn_q, wrEn_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [DATA_W-1:0] wrData_q, wrData_d;
   logic              clrDone_q, clrDone_d;

   logic [NREQ-1:0]   grant;
   logic [PTR_W-1:0]  grantIdx;
   logic [ADDR_W-1:0] grantAddr;
   logic [DATA_W-1:0] grantData;
   logic              arbEn;

   // A pending clear suppresses every grant so it wins over simultaneous requests.
   assign arbEn = (state_q == ARB) && !clr_req;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (PTR_W)
   ) u_rr_arbiter (
      .valid_i     (req_valid),
      .rr_ptr_i    (rrPtr_q),
      .enable_i    (arbEn),
      .grant_o     (grant),
      .grant_idx_o (grantIdx)
   );

   always_comb begin
      grantAddr = '0;
      grantData = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantIdx == PTR_W'(i)) begin
            grantAddr = req_addr[i*ADDR_W +: ADDR_W];
            grantData = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      clrCnt_d  = clrCnt_q;
      wrEn_d    = 1'b0;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      clrDone_d = 1'b0;
      case (state_q)
         ARB: begin
            if (clr_req) begin
               state_d  = CLEAR;
               clrCnt_d = '0;
            end else if (|grant) begin
               wrAddr_d = grantAddr;
               wrData_d = grantData;
`ifdef RF_WR_ZERO_PROTECT_EN
               wrEn_d   = |grantAddr;
`else
               wrEn_d   = 1'b1;
`endif
               rrPtr_d  = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + PTR_W'(1);
            end
         end
         CLEAR: begin
            wrEn_d   = 1'b1;
            wrAddr_d = ADDR_W'(clrCnt_q);
            wrData_d = '0;
            clrCnt_d = clrCnt_q + CNT_W'(1);
            if (clrCnt_q == CNT_W'(RF_DEPTH - 1)) begin
               clrDone_d = 1'b1;
               state_d   = ARB;
               clrCnt_d  = '0;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Reset abandons any clear in progress; the register file keeps whatever was already zeroed.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= ARB;
         rrPtr_q   <= '0;
         clrCnt_q  <= '0;
         wrEn_q    <= 1'b0;
         wrAddr_q  <= '0;
         wrData_q  <= '0;
         clrDone_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         clrCnt_q  <= clrCnt_d;
         wrEn_q    <= wrEn_d;
         wrAddr_q  <= wrAddr_d;
         wrData_q  <= wrData_d;
         clrDone_q <= clrDone_d;
      end
   end

   assign req_ready     = grant;
   assign clr_busy      = (state_q == CLEAR);
   assign clr_done      = clrDone_q;
   assign rf_write_en   = wrEn_q;
   assign rf_write_addr = wrAddr_q;
   assign rf_write_data = wrData_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vector table, clear/reset sequences,
// and randomized traffic against a behavioural model of the arbitration and clear rules.
module tb_regfile_wr_arbiter;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 32;

   logic                   clk = 1'b0;
   logic                   clear_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   clr_req;
   logic                   clr_busy;
   logic                   clr_done;
   logic                   rf_write_en;
   logic [ADDR_W-1:0]      rf_write_addr;
   logic [DATA_W-1:0]      rf_write_data;

   regfile_wr_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk           (clk),
      .clear_n       (clear_n),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .clr_req       (clr_req),
      .clr_busy      (clr_busy),
      .clr_done      (clr_done),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data)
   );

   always #5 clk = ~clk;

   int testsRun  = 0;
   int failCount = 0;

   logic [ADDR_W-1:0] reqAddr [NREQ];
   logic [DATA_W-1:0] reqData [NREQ];
   logic [NREQ-1:0]   lastReady;

   // Behavioural model: mClr is the next register to clear, or -1 while arbitrating.
   int mPtr, mClr, mAddr, mData;
   bit mEn, mDone;

   typedef struct {
      logic [NREQ-1:0]   valid;
      logic [NREQ-1:0]   expReady;
      logic              expEn;
      logic [ADDR_W-1:0] expAddr;
      logic [DATA_W-1:0] expData;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic c);
      req_valid = v;
      clr_req   = c;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = reqAddr[i];
         req_data[i*DATA_W +: DATA_W] = reqData[i];
      end
   endtask

   function automatic void modelReset();
      mPtr = 0; mClr = -1; mEn = 0; mAddr = 0; mData = 0; mDone = 0;
   endfunction

   function automatic int modelGrant();
      for (int k = 0; k < NREQ; k++) begin
         int c = (mPtr + k) % NREQ;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] modelReady();
      logic [NREQ-1:0] r = '0;
      int g = modelGrant();
      if (mClr >= 0 || clr_req || g < 0) return '0;
      r[g] = 1'b1;
      return r;
   endfunction

   function automatic void modelEdge();
      int g = modelGrant();
      mDone = 0;
      if (mClr >= 0) begin
         mEn   = 1;
         mAddr = mClr;
         mData = 0;
         mDone = (mClr == DEPTH - 1);
         mClr  = (mClr == DEPTH - 1) ? -1 : mClr + 1;
      end else if (clr_req) begin
         mEn  = 0;
         mClr = 0;
      end else if (g >= 0) begin
         mAddr = int'(reqAddr[g]);
         mData = int'(reqData[g]);
`ifdef RF_WR_ZERO_PROTECT_EN
         mEn   = (mAddr != 0);
`else
         mEn   = 1;
`endif
         mPtr  = (g + 1) % NREQ;
      end else begin
         mEn = 0;
      end
   endfunction

   // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
   task automatic cycle();
      #2;
      lastReady = req_ready;
      checkOutput("req_ready", req_ready, modelReady());
      checkOutput("clr_busy", clr_busy, (mClr >= 0));
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput("rf_write_en", rf_write_en, mEn);
      checkOutput("rf_write_addr", rf_write_addr, 64'(mAddr));
      checkOutput("rf_write_data", rf_write_data, 64'(mData));
      checkOutput("clr_done", clr_done, mDone);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_en"}, rf_write_en, 0);
      checkOutput({tag, "_addr"}, rf_write_addr, 0);
      checkOutput({tag, "_data"}, rf_write_data, 0);
      checkOutput({tag, "_done"}, clr_done, 0);
      checkOutput({tag, "_ready"}, req_ready, 0);
      checkOutput({tag, "_busy"}, clr_busy, 0);
   endtask

   initial begin
      vecs[0]  = '{3'b001, 3'b001, 1'b1, 5'd3, 16'h1234};
      vecs[1]  = '{3'b111, 3'b010, 1'b1, 5'd7, 16'hBEEF};
      vecs[2]  = '{3'b111, 3'b100, 1'b1, 5'd9, 16'h5A5A};
      vecs[3]  = '{3'b111, 3'b001, 1'b1, 5'd3, 16'h1234};
      vecs[4]  = '{3'b111, 3'b010, 1'b1, 5'd7, 16'hBEEF};
      vecs[5]  = '{3'b111, 3'b100, 1'b1, 5'd9, 16'h5A5A};
      vecs[6]  = '{3'b111, 3'b001, 1'b1, 5'd3, 16'h1234};
      vecs[7]  = '{3'b101, 3'b100, 1'b1, 5'd9, 16'h5A5A};
      vecs[8]  = '{3'b001, 3'b001, 1'b1, 5'd3, 16'h1234};
      vecs[9]  = '{3'b000, 3'b000, 1'b0, 5'd3, 16'h1234};
      vecs[10] = '{3'b010, 3'b010, 1'b1, 5'd7, 16'hBEEF};
      vecs[11] = '{3'b011, 3'b001, 1'b1, 5'd3, 16'h1234};

      reqAddr[0] = 5'd3; reqData[0] = 16'h1234;
      reqAddr[1] = 5'd7; reqData[1] = 16'hBEEF;
      reqAddr[2] = 5'd9; reqData[2] = 16'h5A5A;
      lastReady = '0;
      clear_n = 1'b0;
      applyStimulus('0, 1'b0);
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      clear_n = 1'b1;

      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].valid, 1'b0);
         cycle();
         checkOutput($sformatf("tbl%0d_ready", v), lastReady, vecs[v].expReady);
         checkOutput($sformatf("tbl%0d_write", v), {rf_write_en, rf_write_addr, rf_write_data},
                     {vecs[v].expEn, vecs[v].expAddr, vecs[v].expData});
      end

      // Asynchronous reset in the middle of traffic.
      applyStimulus('0, 1'b0);
      #2;
      clear_n = 1'b0;
      #1;
      checkResetState("reset_mid_op");
      modelReset();
      clear_n = 1'b1;

      // Requester write to R0 right after reset (pointer at 0).
      reqAddr[0] = 5'd0; reqData[0] = 16'hFFFF;
      applyStimulus(3'b001, 1'b0);
      cycle();
      checkOutput("zp_ready", lastReady, 3'b001);
`ifdef RF_WR_ZERO_PROTECT_EN
      checkOutput("zp_en", rf_write_en, 0);
`else
      checkOutput("zp_write", {rf_write_en, rf_write_addr, rf_write_data}, {1'b1, 5'd0, 16'hFFFF});
`endif
      applyStimulus(3'b011, 1'b0);
      cycle();
      checkOutput("zp_ptr_adv", lastReady, 3'b010);
      reqAddr[0] = 5'd3; reqData[0] = 16'h1234;

      // Clear collides with a request from req1.
      applyStimulus(3'b010, 1'b1);
      cycle();
      checkOutput("coll_ready", lastReady, 3'b000);
      checkOutput("coll_en", rf_write_en, 0);
      applyStimulus(3'b010, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         cycle();
         checkOutput($sformatf("clr_w%0d", i), {rf_write_en, rf_write_addr, rf_write_data, clr_done},
                     {1'b1, 5'(i), 16'h0, (i == DEPTH - 1)});
      end
      cycle();
      checkOutput("coll_post_ready", lastReady, 3'b010);
      checkOutput("coll_post_write", {rf_write_en, rf_write_addr, rf_write_data}, {1'b1, 5'd7, 16'hBEEF});

      // Reset while the clear is writing register 12, then restart the clear.
      applyStimulus('0, 1'b1);
      cycle();
      applyStimulus('0, 1'b0);
      repeat (13) cycle();
      checkOutput("midclr_addr12", {rf_write_en, rf_write_addr}, {1'b1, 5'd12});
      #2;
      clear_n = 1'b0;
      #1;
      checkResetState("reset_mid_clr");
      modelReset();
      clear_n = 1'b1;
      applyStimulus('0, 1'b1);
      cycle();
      applyStimulus('0, 1'b0);
      cycle();
      checkOutput("restart_addr0", {rf_write_en, rf_write_addr}, {1'b1, 5'd0});
      repeat (DEPTH - 1) cycle();
      checkOutput("restart_done", {clr_done, rf_write_addr}, {1'b1, 5'd31});

      // Randomized traffic; requesters hold their request until they see ready.
      req_valid = '0;
      for (int n = 0; n < 400; n++) begin
         logic [NREQ-1:0] v;
         v = req_valid;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || lastReady[i]) begin
               v[i]       = ($urandom_range(0, 3) != 0);
               reqAddr[i] = 5'($urandom_range(0, 31));
               reqData[i] = 16'($urandom);
            end
         end
         applyStimulus(v, ($urandom_range(0, 39) == 0));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
